muldiv_ctrl: RTL

//  Sequencer between the multicycle control unit and the iterative mult/div datapaths.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the mult/div sequencer.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH       = 32;
  localparam int unsigned MULDIV_TIMEOUT_CYC = 40;
  localparam int unsigned WDOG_CNT_W         = 8;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    COMMIT = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencer between the multicycle control unit and the iterative mult/div units.
// Latches one request, pulses the selected unit's start, waits for its end and
// commits the result into HI/LO. Define MULDIV_WDOG_EN to add a wait watchdog.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH       = MULDIV_WIDTH,
  parameter int unsigned TIMEOUT_CYC = MULDIV_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             req_is_div,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] u_a,
  output logic [WIDTH-1:0] u_b,
  output logic             mult_start,
  output logic             div_start,
  input  logic             mult_end,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             div_end,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo
);

  // The watchdog counter is 8 bits wide; reject limits it can never reach.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= 2**WDOG_CNT_W) begin : g_bad_timeout
    $error("muldiv_ctrl: TIMEOUT_CYC out of range for the wait counter");
  end

  muldiv_state_e    state_q, state_d;
  logic             op_q, op_d;
  logic             armed_q, armed_d;
  logic             busy_d, done_d, div_zero_d, timeout_d;
  logic             mult_start_d, div_start_d;
  logic [WIDTH-1:0] hi_d, lo_d, u_a_d, u_b_d;
  logic             sel_end;
`ifdef MULDIV_WDOG_EN
  logic [WDOG_CNT_W-1:0] cnt_q, cnt_d;
`endif

  // State and registered outputs; reset aborts any op without committing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      armed_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      timeout    <= 1'b0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      u_a        <= '0;
      u_b        <= '0;
`ifdef MULDIV_WDOG_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      armed_q    <= armed_d;
      busy       <= busy_d;
      done       <= done_d;
      div_zero   <= div_zero_d;
      timeout    <= timeout_d;
      mult_start <= mult_start_d;
      div_start  <= div_start_d;
      hi         <= hi_d;
      lo         <= lo_d;
      u_a        <= u_a_d;
      u_b        <= u_b_d;
`ifdef MULDIV_WDOG_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    armed_d      = armed_q;
    busy_d       = busy;
    done_d       = 1'b0;
    div_zero_d   = 1'b0;
    timeout_d    = 1'b0;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    hi_d         = hi;
    lo_d         = lo;
    u_a_d        = u_a;
    u_b_d        = u_b;
`ifdef MULDIV_WDOG_EN
    cnt_d        = cnt_q;
`endif
    sel_end      = (op_q == OP_DIV) ? div_end : mult_end;

    case (state_q)
      // COMMIT behaves like IDLE for acceptance so back-to-back ops lose no cycle.
      IDLE, COMMIT: begin
        state_d = IDLE;
        if (req) begin
          u_a_d = req_a;
          u_b_d = req_b;
          op_d  = req_is_div;
          if (req_is_div == OP_DIV && req_b == '0) begin
            div_zero_d = 1'b1;
          end else begin
            state_d      = LAUNCH;
            busy_d       = 1'b1;
            mult_start_d = (req_is_div == OP_MULT);
            div_start_d  = (req_is_div == OP_DIV);
          end
        end
      end
      // An end still high from before the launch must drop before it is trusted.
      LAUNCH: begin
        state_d = WAIT;
        armed_d = !sel_end;
`ifdef MULDIV_WDOG_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (sel_end && armed_q) begin
          state_d = COMMIT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          hi_d    = (op_q == OP_DIV) ? div_hi : mult_hi;
          lo_d    = (op_q == OP_DIV) ? div_lo : mult_lo;
        end else begin
          if (!sel_end) armed_d = 1'b1;
`ifdef MULDIV_WDOG_EN
          cnt_d = cnt_q + WDOG_CNT_W'(1);
          if (cnt_d == WDOG_CNT_W'(TIMEOUT_CYC)) begin
            state_d   = IDLE;
            busy_d    = 1'b0;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
